// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared stall encodings and control-state type for pipe_ctrl.
package pipe_ctrl_pkg;
   localparam int STALL_W = 6;
   localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;
   localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
   localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
   localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
   localparam logic [31:0] ZERO_WORD = 32'h0;
   typedef enum logic [1:0] {
      CTRL_RUN    = 2'd0,
      CTRL_FLUSH  = 2'd1,
      CTRL_REFILL = 2'd2
   } ctrl_state_e;
endpackage

// File: rtl/pipe_ctrl_wdog.sv
// pipe_ctrl_wdog: counts consecutive stalled cycles and raises a sticky timeout flag.
module pipe_ctrl_wdog
   import pipe_ctrl_pkg::*;
#(
   parameter int WDOG_LIMIT = 1024,
   parameter int CNT_W      = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic stall_act,
   output logic timeout
);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WDOG_LIMIT);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic timeout_q, timeout_d;
   always_comb begin
      cnt_d = stall_act ? ((cnt_q == LIMIT) ? cnt_q : cnt_q + 1'b1) : '0;
      timeout_d = timeout_q | (cnt_d == LIMIT);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         timeout_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         timeout_q <= timeout_d;
      end
   end
   assign timeout = timeout_q;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: per-stage stall merge and RUN/FLUSH/REFILL exception sequencing.
// Define PIPE_CTRL_WDOG_EN to build the stall watchdog; otherwise wdog_timeout is 0.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int REFILL_CYC = 2,
   parameter int WDOG_LIMIT = 1024,
   parameter int CNT_W      = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stallreq_id,
   input  logic               stallreq_ex,
   input  logic               stallreq_mem,
   input  logic               excp_valid,
   input  logic [31:0]        excp_vector,
   output logic [STALL_W-1:0] stall,
   output logic               flush,
   output logic [31:0]        new_pc,
   output logic               refill,
   output logic               wdog_timeout
);
   localparam logic [3:0] REFILL_LD = 4'(REFILL_CYC - 1);
   ctrl_state_e state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic flush_q, flush_d;
   logic [31:0] new_pc_q, new_pc_d;
   logic take_excp;
   always_comb begin
      take_excp = excp_valid && (state_q != CTRL_FLUSH);
      state_d = take_excp ? CTRL_FLUSH :
                (state_q == CTRL_FLUSH) ? CTRL_REFILL :
                (state_q == CTRL_REFILL && cnt_q == 4'd0) ? CTRL_RUN : state_q;
      cnt_d = (!take_excp && state_q == CTRL_FLUSH) ? REFILL_LD :
              (!take_excp && state_q == CTRL_REFILL && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
      flush_d = (state_d == CTRL_FLUSH);
      new_pc_d = take_excp ? excp_vector : new_pc_q;
      // Bubbles only in REFILL, so a load-use request there has nothing to protect.
      stall = (rst || take_excp || state_q == CTRL_FLUSH) ? STALL_NONE :
              stallreq_mem ? STALL_MEM :
              stallreq_ex ? STALL_EX :
              (stallreq_id && state_q != CTRL_REFILL) ? STALL_ID : STALL_NONE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= CTRL_RUN;
         cnt_q <= 4'd0;
         flush_q <= 1'b0;
         new_pc_q <= ZERO_WORD;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         flush_q <= flush_d;
         new_pc_q <= new_pc_d;
      end
   end
   assign flush = flush_q;
   assign new_pc = new_pc_q;
   assign refill = (state_q == CTRL_REFILL);
`ifdef PIPE_CTRL_WDOG_EN
   pipe_ctrl_wdog #(.WDOG_LIMIT(WDOG_LIMIT), .CNT_W(CNT_W)) u_wdog (
      .clk(clk),
      .rst(rst),
      .stall_act(|stall),
      .timeout(wdog_timeout)
   );
`else
   assign wdog_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed checks of stall priority, flush/refill sequencing, reset and watchdog.
module tb_pipe_ctrl;
   logic clk = 1'b0;
   logic rst, stallreq_id, stallreq_ex, stallreq_mem, excp_valid;
   logic [31:0] excp_vector;
   logic [5:0] stall;
   logic flush, refill, wdog_timeout;
   logic [31:0] new_pc;
   int total = 0;
   int passed = 0;

   pipe_ctrl #(.REFILL_CYC(2), .WDOG_LIMIT(8), .CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
      .excp_valid(excp_valid), .excp_vector(excp_vector),
      .stall(stall), .flush(flush), .new_pc(new_pc), .refill(refill),
      .wdog_timeout(wdog_timeout)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0; excp_valid = 0; excp_vector = 32'h0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1; stallreq_mem = 1;
      step(); step();
      total++; if (stall !== 6'b000000) $display("FAIL reset_stall_in_rst got=%b exp=000000", stall); else passed++;
      rst = 0; stallreq_mem = 0;
      #1;
      total++; if ({flush, refill, new_pc, stall} !== {1'b0, 1'b0, 32'h0, 6'b0})
         $display("FAIL reset_outputs got flush=%b refill=%b new_pc=%h stall=%b exp 0/0/0/0", flush, refill, new_pc, stall);
      else passed++;
   endtask

   task automatic test_stall_prio();
      stallreq_id = 1; stallreq_ex = 1; #1;
      total++; if (stall !== 6'b001111) $display("FAIL prio_id_ex got=%b exp=001111", stall); else passed++;
      stallreq_mem = 1; #1;
      total++; if (stall !== 6'b011111) $display("FAIL prio_all got=%b exp=011111", stall); else passed++;
      stallreq_mem = 0; stallreq_ex = 0; #1;
      total++; if (stall !== 6'b000111) $display("FAIL prio_id got=%b exp=000111", stall); else passed++;
      stallreq_id = 0; step();
      total++; if (stall !== 6'b000000 || flush !== 1'b0) $display("FAIL prio_none got stall=%b flush=%b exp 000000/0", stall, flush); else passed++;
   endtask

   task automatic test_exception();
      stallreq_mem = 1; excp_valid = 1; excp_vector = 32'h20; #1;
      total++; if (stall !== 6'b000000) $display("FAIL excp_stall got=%b exp=000000", stall); else passed++;
      step(); excp_valid = 0; #1;
      total++; if (flush !== 1'b1 || new_pc !== 32'h20 || refill !== 1'b0 || stall !== 6'b0)
         $display("FAIL excp_flush got flush=%b new_pc=%h refill=%b stall=%b exp 1/20/0/0", flush, new_pc, refill, stall);
      else passed++;
      step();
      total++; if (flush !== 1'b0 || refill !== 1'b1 || stall !== 6'b011111 || new_pc !== 32'h20)
         $display("FAIL excp_refill1 got flush=%b refill=%b stall=%b new_pc=%h exp 0/1/011111/20", flush, refill, stall, new_pc);
      else passed++;
      stallreq_mem = 0; stallreq_id = 1; #1;
      total++; if (stall !== 6'b000000) $display("FAIL refill_ignores_id got=%b exp=000000", stall); else passed++;
      step();
      total++; if (refill !== 1'b1) $display("FAIL excp_refill2 got=%b exp=1", refill); else passed++;
      step();
      total++; if (refill !== 1'b0 || stall !== 6'b000111) $display("FAIL excp_run got refill=%b stall=%b exp 0/000111", refill, stall); else passed++;
      stallreq_id = 0;
   endtask

   task automatic test_refill_excp();
      excp_valid = 1; excp_vector = 32'h20;
      step(); excp_valid = 0;
      step();
      excp_valid = 1; excp_vector = 32'h40; stallreq_id = 1; #1;
      total++; if (stall !== 6'b000000) $display("FAIL refill_excp_stall got=%b exp=000000", stall); else passed++;
      step(); excp_valid = 0; stallreq_id = 0; #1;
      total++; if (flush !== 1'b1 || new_pc !== 32'h40 || refill !== 1'b0)
         $display("FAIL refill_excp_flush got flush=%b new_pc=%h refill=%b exp 1/40/0", flush, new_pc, refill);
      else passed++;
      step(); step(); step();
      total++; if (refill !== 1'b0 || flush !== 1'b0) $display("FAIL refill_excp_drain got refill=%b flush=%b exp 0/0", refill, flush); else passed++;
   endtask

   task automatic test_last_refill_excp();
      excp_valid = 1; excp_vector = 32'h60;
      step();
      excp_valid = 1; excp_vector = 32'h99;
      step(); excp_valid = 0;
      total++; if (refill !== 1'b1 || new_pc !== 32'h60) $display("FAIL flush_ignores_excp got refill=%b new_pc=%h exp 1/60", refill, new_pc); else passed++;
      step();
      excp_valid = 1; excp_vector = 32'h80;
      step(); excp_valid = 0; #1;
      total++; if (flush !== 1'b1 || new_pc !== 32'h80 || refill !== 1'b0)
         $display("FAIL last_refill_excp got flush=%b new_pc=%h refill=%b exp 1/80/0", flush, new_pc, refill);
      else passed++;
      step(); step(); step();
   endtask

   task automatic test_rst_flush();
      excp_valid = 1; excp_vector = 32'ha0;
      step(); excp_valid = 0;
      total++; if (flush !== 1'b1) $display("FAIL rst_flush_pre got=%b exp=1", flush); else passed++;
      rst = 1;
      step(); rst = 0; #1;
      total++; if (flush !== 1'b0 || refill !== 1'b0 || new_pc !== 32'h0)
         $display("FAIL rst_flush got flush=%b refill=%b new_pc=%h exp 0/0/0", flush, refill, new_pc);
      else passed++;
      step();
      total++; if (refill !== 1'b0 || flush !== 1'b0) $display("FAIL rst_flush_run got refill=%b flush=%b exp 0/0", refill, flush); else passed++;
   endtask

   task automatic test_wdog();
      stallreq_ex = 1;
      repeat (7) step();
      total++; if (wdog_timeout !== 1'b0) $display("FAIL wdog_early got=%b exp=0", wdog_timeout); else passed++;
      step();
`ifdef PIPE_CTRL_WDOG_EN
      total++; if (wdog_timeout !== 1'b1) $display("FAIL wdog_trip got=%b exp=1", wdog_timeout); else passed++;
      stallreq_ex = 0;
      step(); step();
      total++; if (wdog_timeout !== 1'b1) $display("FAIL wdog_sticky got=%b exp=1", wdog_timeout); else passed++;
      rst = 1; step(); rst = 0;
      total++; if (wdog_timeout !== 1'b0) $display("FAIL wdog_rst got=%b exp=0", wdog_timeout); else passed++;
      stallreq_ex = 1; repeat (7) step();
      stallreq_ex = 0; step();
      stallreq_ex = 1; repeat (7) step();
      stallreq_ex = 0; step(); step();
      total++; if (wdog_timeout !== 1'b0) $display("FAIL wdog_7_idle got=%b exp=0", wdog_timeout); else passed++;
`else
      repeat (4) step();
      total++; if (wdog_timeout !== 1'b0) $display("FAIL wdog_disabled got=%b exp=0", wdog_timeout); else passed++;
      stallreq_ex = 0;
`endif
   endtask

   initial begin
      rst = 1;
      idle_inputs();
      test_reset();
      test_stall_prio();
      test_exception();
      test_refill_excp();
      test_last_refill_excp();
      test_rst_flush();
      test_wdog();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
